// File: rtl/ycbcr2rgb.sv
// Full-range BT.601 (JPEG) YCbCr 4:4:4 to 8-bit RGB pixel-stream converter.
// Four register stages: offset removal, coefficient products, rounded sums,
// clamp plus href gating. vsync/href ride a matching 4-deep shift register.
module ycbcr2rgb #(
  parameter int unsigned K_R_CR = 359,  // 1.402    * 256
  parameter int unsigned K_G_CB = 88,   // 0.344136 * 256
  parameter int unsigned K_G_CR = 183,  // 0.714136 * 256
  parameter int unsigned K_B_CB = 454   // 1.772    * 256
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       per_img_vsync,
  input  logic       per_img_href,
  input  logic [7:0] per_img_Y,
  input  logic [7:0] per_img_Cb,
  input  logic [7:0] per_img_Cr,
  output logic       post_img_vsync,
  output logic       post_img_href,
  output logic [7:0] post_img_red,
  output logic [7:0] post_img_green,
  output logic [7:0] post_img_blue
);

  localparam logic signed [18:0] KRCr = 19'(K_R_CR);
  localparam logic signed [18:0] KGCb = 19'(K_G_CB);
  localparam logic signed [18:0] KGCr = 19'(K_G_CR);
  localparam logic signed [18:0] KBCb = 19'(K_B_CB);
  // Half an LSB of the 2^8 scaling, so the final shift rounds to nearest.
  localparam logic signed [19:0] Round = 20'sd128;

  // Saturate a 2^8-scaled sum to 0..255 without ever wrapping.
  function automatic logic [7:0] clamp8(input logic signed [19:0] s);
    logic signed [19:0] v;
    v = s >>> 8;
    if (v < 20'sd0) begin
      clamp8 = 8'd0;
    end else if (v > 20'sd255) begin
      clamp8 = 8'd255;
    end else begin
      clamp8 = v[7:0];
    end
  endfunction

  // Sync delay line
  logic [3:0] vsync_q, vsync_d;
  logic [3:0] href_q, href_d;

  // Stage 1: centred chroma and scaled luma
  logic signed [8:0]  dcb_q, dcb_d;
  logic signed [8:0]  dcr_q, dcr_d;
  logic signed [17:0] ys1_q, ys1_d;

  // Stage 2: products (luma carried alongside)
  logic signed [18:0] pr_q, pr_d;
  logic signed [18:0] pgb_q, pgb_d;
  logic signed [18:0] pgr_q, pgr_d;
  logic signed [18:0] pb_q, pb_d;
  logic signed [17:0] ys2_q, ys2_d;

  // Stage 3: rounded sums
  logic signed [19:0] sr_q, sr_d;
  logic signed [19:0] sg_q, sg_d;
  logic signed [19:0] sb_q, sb_d;

  // Stage 4: clamped, gated outputs
  logic [7:0] red_q, red_d;
  logic [7:0] green_q, green_d;
  logic [7:0] blue_q, blue_d;

  // Shift syncs one place per clock so they land with the data at stage 4.
  always_comb begin
    vsync_d = {vsync_q[2:0], per_img_vsync};
    href_d  = {href_q[2:0], per_img_href};
  end

  // Stage 1 next-state: remove the 128 chroma offset, scale luma by 2^8.
  always_comb begin
    dcb_d = $signed({1'b0, per_img_Cb}) - 9'sd128;
    dcr_d = $signed({1'b0, per_img_Cr}) - 9'sd128;
    ys1_d = $signed({2'b00, per_img_Y, 8'h00});
  end

  // Stage 2 next-state: signed coefficient products.
  always_comb begin
    pr_d  = KRCr * 19'(dcr_q);
    pgb_d = KGCb * 19'(dcb_q);
    pgr_d = KGCr * 19'(dcr_q);
    pb_d  = KBCb * 19'(dcb_q);
    ys2_d = ys1_q;
  end

  // Stage 3 next-state: per-channel sums with rounding constant.
  always_comb begin
    sr_d = 20'(ys2_q) + 20'(pr_q) + Round;
    sg_d = 20'(ys2_q) - 20'(pgb_q) - 20'(pgr_q) + Round;
    sb_d = 20'(ys2_q) + 20'(pb_q) + Round;
  end

  // Stage 4 next-state: clamp, and blank data whenever the aligned href is low.
  always_comb begin
    red_d   = 8'd0;
    green_d = 8'd0;
    blue_d  = 8'd0;
    if (href_q[2]) begin
      red_d   = clamp8(sr_q);
      green_d = clamp8(sg_q);
      blue_d  = clamp8(sb_q);
    end
  end

  // Sync delay line registers.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      vsync_q <= 4'd0;
      href_q  <= 4'd0;
    end else begin
      vsync_q <= vsync_d;
      href_q  <= href_d;
    end
  end

  // Stage 1 registers.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      dcb_q <= '0;
      dcr_q <= '0;
      ys1_q <= '0;
    end else begin
      dcb_q <= dcb_d;
      dcr_q <= dcr_d;
      ys1_q <= ys1_d;
    end
  end

  // Stage 2 registers.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      pr_q  <= '0;
      pgb_q <= '0;
      pgr_q <= '0;
      pb_q  <= '0;
      ys2_q <= '0;
    end else begin
      pr_q  <= pr_d;
      pgb_q <= pgb_d;
      pgr_q <= pgr_d;
      pb_q  <= pb_d;
      ys2_q <= ys2_d;
    end
  end

  // Stage 3 registers.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      sr_q <= '0;
      sg_q <= '0;
      sb_q <= '0;
    end else begin
      sr_q <= sr_d;
      sg_q <= sg_d;
      sb_q <= sb_d;
    end
  end

  // Stage 4 output registers.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      red_q   <= 8'd0;
      green_q <= 8'd0;
      blue_q  <= 8'd0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign post_img_vsync = vsync_q[3];
  assign post_img_href  = href_q[3];
  assign post_img_red   = red_q;
  assign post_img_green = green_q;
  assign post_img_blue  = blue_q;

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Directed bench for ycbcr2rgb: a table of hand-computed pixels streamed in
// various href/vsync patterns, checked every cycle against a 4-cycle delay
// model, plus hand-written latency and asynchronous-reset sequences.
module tb_ycbcr2rgb;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       per_img_vsync = 1'b0;
  logic       per_img_href = 1'b0;
  logic [7:0] per_img_Y = 8'd0;
  logic [7:0] per_img_Cb = 8'd0;
  logic [7:0] per_img_Cr = 8'd0;
  logic       post_img_vsync;
  logic       post_img_href;
  logic [7:0] post_img_red;
  logic [7:0] post_img_green;
  logic [7:0] post_img_blue;

  ycbcr2rgb dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .per_img_vsync (per_img_vsync),
    .per_img_href  (per_img_href),
    .per_img_Y     (per_img_Y),
    .per_img_Cb    (per_img_Cb),
    .per_img_Cr    (per_img_Cr),
    .post_img_vsync(post_img_vsync),
    .post_img_href (post_img_href),
    .post_img_red  (post_img_red),
    .post_img_green(post_img_green),
    .post_img_blue (post_img_blue)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [7:0] y, cb, cr;
    logic [7:0] r, g, b;
  } vec_t;

  localparam int NVec = 10;
  vec_t tbl[NVec];

  int n_tot = 0;
  int n_pass = 0;
  int n_in = 0;
  int n_out = 0;
  int cur_idx = 0;
  bit chk_en = 1'b0;

  // Expected-output delay model: inputs seen at each edge emerge 4 edges later.
  logic [3:0] m_h = 4'd0;
  logic [3:0] m_v = 4'd0;
  int m_i0 = 0, m_i1 = 0, m_i2 = 0, m_i3 = 0;

  always @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      m_h <= 4'd0;
      m_v <= 4'd0;
    end else begin
      m_h  <= {m_h[2:0], per_img_href};
      m_v  <= {m_v[2:0], per_img_vsync};
      m_i0 <= cur_idx;
      m_i1 <= m_i0;
      m_i2 <= m_i1;
      m_i3 <= m_i2;
      if (per_img_href) n_in <= n_in + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
  endtask

  // One clock: check the settled outputs at the falling edge, then drive new inputs.
  task automatic cyc(input bit h, input bit v, input int idx);
    logic [23:0] exp_rgb;
    @(negedge sys_clk);
    if (chk_en) begin
      exp_rgb = m_h[3] ? {tbl[m_i3].r, tbl[m_i3].g, tbl[m_i3].b} : 24'h0;
      check("vsync", {31'd0, post_img_vsync}, {31'd0, m_v[3]});
      check("href", {31'd0, post_img_href}, {31'd0, m_h[3]});
      check("rgb", {8'd0, post_img_red, post_img_green, post_img_blue}, {8'd0, exp_rgb});
      if (post_img_href) n_out++;
    end
    per_img_href  = h;
    per_img_vsync = v;
    cur_idx       = idx;
    per_img_Y     = tbl[idx].y;
    per_img_Cb    = tbl[idx].cb;
    per_img_Cr    = tbl[idx].cr;
  endtask

  task automatic rnd_idx(output int idx);
    idx = int'($urandom_range(0, NVec - 1));
  endtask

  // Frame: vsync lead, lines of back-to-back pixels separated by idle gaps.
  task automatic frame(input int lines, input int ppl, input int gap);
    int k = 0;
    int r;
    for (int i = 0; i < 5; i++) begin
      rnd_idx(r);
      cyc(1'b0, 1'b1, r);
    end
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ppl; p++) begin
        cyc(1'b1, 1'b1, k % NVec);
        k++;
      end
      for (int g = 0; g < gap; g++) begin
        rnd_idx(r);
        cyc(1'b0, 1'b1, r);
      end
    end
  endtask

  initial begin
    int first, hits, r, base_in, base_out;
    tbl[0] = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
    tbl[1] = '{8'd255, 8'd128, 8'd255, 8'd255, 8'd164, 8'd255};
    tbl[2] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd136, 8'd0};
    tbl[3] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd121, 8'd255};
    tbl[4] = '{8'd76,  8'd85,  8'd255, 8'd254, 8'd0,   8'd0};
    tbl[5] = '{8'd29,  8'd255, 8'd107, 8'd0,   8'd0,   8'd254};
    tbl[6] = '{8'd0,   8'd128, 8'd128, 8'd0,   8'd0,   8'd0};
    tbl[7] = '{8'd255, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255};
    tbl[8] = '{8'd100, 8'd128, 8'd200, 8'd201, 8'd49,  8'd100};
    tbl[9] = '{8'd50,  8'd200, 8'd60,  8'd0,   8'd74,  8'd178};

    #1 sys_rst = 1'b0;
    chk_en = 1'b1;
    // Reset with live inputs: everything stays 0.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, i);
    check("reset_outs", {19'd0, post_img_vsync, post_img_href, post_img_red,
                         post_img_green, post_img_blue}, 32'd0);
    cyc(1'b0, 1'b0, 0);
    #2 sys_rst = 1'b1;
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 0);

    // Every table vector as an isolated single-cycle pixel.
    for (int i = 0; i < NVec; i++) begin
      cyc(1'b1, 1'b1, i);
      for (int j = 0; j < 6; j++) begin
        rnd_idx(r);
        cyc(1'b0, 1'b1, r);
      end
    end

    // Neutral grey: exact latency and a single output cycle.
    cyc(1'b1, 1'b0, 0);
    first = -1;
    hits  = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge sys_clk);
      #1;
      if (k == 1) per_img_href = 1'b0;
      if (post_img_href) begin
        hits++;
        if (first < 0) first = k;
        check("grey_rgb", {8'd0, post_img_red, post_img_green, post_img_blue}, 32'h808080);
      end
    end
    check("grey_latency", first, 4);
    check("grey_hits", hits, 1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 0);

    // Two frames separated by a 1-cycle vsync gap, then a long random stream.
    base_in  = n_in;
    base_out = n_out;
    frame(4, 16, 5);
    cyc(1'b0, 1'b0, 0);
    frame(4, 16, 5);
    for (int i = 0; i < 1000; i++) begin
      rnd_idx(r);
      cyc(($urandom_range(0, 3) != 0), 1'b1, r);
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 0);
    check("pix_count", n_out - base_out, n_in - base_in);
    check("pix_count_min", {31'd0, (n_out - base_out) > 700}, 32'd1);

    // Asynchronous reset in the middle of a line of grey pixels.
    frame(2, 10, 5);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 0);
    check("pre_rst_rgb", {8'd0, post_img_red, post_img_green, post_img_blue}, 32'h808080);
    @(posedge sys_clk);
    #2 sys_rst = 1'b0;
    #1;
    check("rst_async", {19'd0, post_img_vsync, post_img_href, post_img_red,
                        post_img_green, post_img_blue}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 7);
    #2 sys_rst = 1'b1;
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 0);
    frame(3, 12, 5);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
